decode_stage: RTL and testbench

- Instruction-decode stage of the basic control path. It sits directly upstream and downstream of the register file.
- Drives the register file read addresses (ra1/ra2) from the fetched instruction and consumes the read data (rd1/rd2).
- Bypasses the same-cycle writeback, extracts the immediate, detects load-use hazards, and registers everything into the ID/EX pipeline register consumed by execute.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/decode_stage_imm_gen.sv | 39 +++
 rtl/decode_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I instruction-decode stage.
package decode_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM:
        is_legal_opcode = 1'b1;
      default:
        is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate-format decode and sign-extended immediate extraction.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [31:0]       instr_i,
  output imm_type_e         imm_type_o,
  output logic [XLEN_P-1:0] imm_o
);

  logic sgn;
  assign sgn = instr_i[31];

  always_comb begin
    case (instr_i[6:0])
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: imm_type_o = IMM_I;
      STORE:                                imm_type_o = IMM_S;
      BRANCH:                               imm_type_o = IMM_B;
      LUI, AUIPC:                           imm_type_o = IMM_U;
      JAL:                                  imm_type_o = IMM_J;
      default:                              imm_type_o = IMM_NONE;
    endcase
  end

  always_comb begin
    case (imm_type_o)
      IMM_I: imm_o = {{(XLEN_P-12){sgn}}, instr_i[31:20]};
      IMM_S: imm_o = {{(XLEN_P-12){sgn}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{(XLEN_P-13){sgn}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm_o = {{(XLEN_P-32){sgn}}, instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{(XLEN_P-21){sgn}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile addressing, writeback bypass, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid,
  input  logic [31:0]         if_instr,
  input  logic [XLEN_P-1:0]   if_pc,
  output logic [REG_AW_P-1:0] ra1,
  output logic [REG_AW_P-1:0] ra2,
  input  logic [XLEN_P-1:0]   rd1,
  input  logic [XLEN_P-1:0]   rd2,
  input  logic                wb_we,
  input  logic [REG_AW_P-1:0] wb_wa,
  input  logic [XLEN_P-1:0]   wb_wd,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [XLEN_P-1:0]   ex_pc,
  output logic [XLEN_P-1:0]   ex_rs1_val,
  output logic [XLEN_P-1:0]   ex_rs2_val,
  output logic [XLEN_P-1:0]   ex_imm,
  output logic [REG_AW_P-1:0] ex_rd,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic                ex_funct7b5,
  output logic                ex_reg_write,
  output logic                ex_is_load,
  output logic                ex_illegal
);

  // Flow control: fetch presents if_instr/if_pc qualified by if_valid and must
  // hold them unchanged in any cycle where id_stall is high; the slot is
  // consumed on a rising edge only when id_stall is low.

  logic [6:0]          opcode;
  logic                legal;
  logic [REG_AW_P-1:0] rd_field;
  imm_type_e           imm_type;
  logic [XLEN_P-1:0]   imm;
  logic                uses_rs1, uses_rs2, hazard;
  logic [XLEN_P-1:0]   src1, src2;

  logic                valid_d, valid_q;
  logic [XLEN_P-1:0]   pc_d, pc_q, rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q;
  logic [REG_AW_P-1:0] rd_d, rd_q;
  logic [6:0]          opcode_d, opcode_q;
  logic [2:0]          funct3_d, funct3_q;
  logic                f7b5_d, f7b5_q, reg_write_d, reg_write_q;
  logic                is_load_d, is_load_q, illegal_d, illegal_q;

  imm_gen #(.XLEN_P(XLEN_P)) u_imm_gen (
    .instr_i    (if_instr),
    .imm_type_o (imm_type),
    .imm_o      (imm)
  );

  assign ra1      = if_instr[19:15];
  assign ra2      = if_instr[24:20];
  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[11:7];
  assign legal    = is_legal_opcode(opcode);

  assign uses_rs1 = !((imm_type == IMM_U) || (imm_type == IMM_J));
  assign uses_rs2 = (opcode == OP) || (imm_type == IMM_S) || (imm_type == IMM_B);

  // The regfile writes on the same edge we capture, so forward wb data directly.
  assign src1 = (ra1 == '0) ? '0 : ((wb_we && (wb_wa == ra1)) ? wb_wd : rd1);
  assign src2 = (ra2 == '0) ? '0 : ((wb_we && (wb_wa == ra2)) ? wb_wd : rd2);

  assign hazard = valid_q && is_load_q && (rd_q != '0) && if_valid &&
                  ((uses_rs1 && (rd_q == ra1)) || (uses_rs2 && (rd_q == ra2)));

  assign id_stall = ex_stall | (hazard & ~flush);

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    f7b5_d      = f7b5_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    illegal_d   = illegal_q;
    if (flush || (!ex_stall && (hazard || !if_valid))) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      imm_d       = '0;
      rd_d        = '0;
      opcode_d    = '0;
      funct3_d    = '0;
      f7b5_d      = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
      illegal_d   = 1'b0;
    end else if (!ex_stall) begin
      valid_d     = 1'b1;
      pc_d        = if_pc;
      rs1_d       = src1;
      rs2_d       = src2;
      imm_d       = imm;
      rd_d        = rd_field;
      opcode_d    = opcode;
      funct3_d    = if_instr[14:12];
      f7b5_d      = if_instr[30];
      reg_write_d = legal && (rd_field != '0) && (opcode != STORE) && (opcode != BRANCH);
      is_load_d   = (opcode == LOAD);
      illegal_d   = !legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      f7b5_q      <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      f7b5_q      <= f7b5_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_val   = rs1_q;
  assign ex_rs2_val   = rs2_q;
  assign ex_imm       = imm_q;
  assign ex_rd        = rd_q;
  assign ex_opcode    = opcode_q;
  assign ex_funct3    = funct3_q;
  assign ex_funct7b5  = f7b5_q;
  assign ex_reg_write = reg_write_q;
  assign ex_is_load   = is_load_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expected values.
module tb_decode_stage;

  logic        clk, rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        ex_stall, flush, id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_is_load, ex_illegal;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .wb_we        (wb_we),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7b5  (ex_funct7b5),
    .ex_reg_write (ex_reg_write),
    .ex_is_load   (ex_is_load),
    .ex_illegal   (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rd1 = '0; rd2 = '0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    ex_stall = 1'b0; flush = 1'b0;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_rs1", ex_rs1_val, 0);
    chk("rst_imm", ex_imm, 0);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h100);
    rd1 = 32'hAAAA1111; rd2 = 32'hBBBB2222;
    #1;
    chk("add_ra1", ra1, 1);
    chk("add_ra2", ra2, 2);
    chk("add_idstall", id_stall, 0);
    tick();
    chk("add_rs1", ex_rs1_val, 32'hAAAA1111);
    chk("add_rs2", ex_rs2_val, 32'hBBBB2222);
    chk("add_rd", ex_rd, 3);
    chk("add_rw", ex_reg_write, 1);
    chk("add_valid", ex_valid, 1);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_op", ex_opcode, 7'h33);
    chk("add_imm", ex_imm, 0);

    // Bypass of same-cycle writeback over stale rd1
    wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h12345678; rd1 = 32'hDEADBEEF;
    tick();
    chk("byp_rs1", ex_rs1_val, 32'h12345678);
    chk("byp_rs2", ex_rs2_val, 32'hBBBB2222);

    // ADD x3,x0,x2 with a writeback to x0: operand must stay 0
    drive(32'h002001B3, 32'h104);
    wb_wa = 5'd0; wb_wd = 32'hFFFFFFFF; rd1 = 32'h55555555;
    tick();
    chk("x0_rs1", ex_rs1_val, 0);
    chk("x0_rs2", ex_rs2_val, 32'hBBBB2222);
    wb_we = 1'b0;

    // Load-use: LW x5,0(x1) then ADD x6,x5,x5
    drive(32'h0000A283, 32'h108);
    tick();
    chk("lw_isload", ex_is_load, 1);
    chk("lw_rd", ex_rd, 5);
    chk("lw_funct3", ex_funct3, 2);
    drive(32'h00528333, 32'h10C);
    #1;
    chk("lu_stall", id_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_stall_clear", id_stall, 0);
    tick();
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 6);
    chk("lu_issue_pc", ex_pc, 32'h10C);

    // Load to x0 never stalls
    drive(32'h0000A003, 32'h110);
    tick();
    drive(32'h00000333, 32'h114);
    #1;
    chk("lw0_nostall", id_stall, 0);
    tick();
    chk("lw0_valid", ex_valid, 1);
    chk("lw0_rd", ex_rd, 6);

    // Immediates
    drive(32'hFFF00093, 32'h118);   // ADDI x1,x0,-1
    tick();
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rw", ex_reg_write, 1);
    drive(32'hFE000EE3, 32'h11C);   // BEQ x0,x0,-4
    tick();
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("beq_rw", ex_reg_write, 0);
    drive(32'h123450B7, 32'h120);   // LUI x1,0x12345
    tick();
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", ex_rd, 1);
    drive(32'hFE20AC23, 32'h124);   // SW x2,-8(x1)
    tick();
    chk("sw_imm", ex_imm, 32'hFFFFFFF8);
    chk("sw_rw", ex_reg_write, 0);
    drive(32'h008000EF, 32'h128);   // JAL x1,8
    tick();
    chk("jal_imm", ex_imm, 32'h00000008);
    chk("jal_rw", ex_reg_write, 1);

    // flush together with ex_stall loads a bubble
    drive(32'h002081B3, 32'h12C);
    rd1 = 32'hAAAA1111; rd2 = 32'hBBBB2222;
    flush = 1'b1; ex_stall = 1'b1;
    #1;
    chk("fs_idstall", id_stall, 1);
    tick();
    chk("fs_valid", ex_valid, 0);
    chk("fs_imm", ex_imm, 0);
    flush = 1'b0; ex_stall = 1'b0;
    tick();
    chk("post_fs_valid", ex_valid, 1);

    // ex_stall holds the register for 3 cycles while fetch changes
    ex_stall = 1'b1;
    drive(32'hFFF00093, 32'h130);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd", ex_rd, 3);
      chk("hold_rs1", ex_rs1_val, 32'hAAAA1111);
      chk("hold_pc", ex_pc, 32'h12C);
    end
    ex_stall = 1'b0;

    // flush suppresses a load-use stall
    drive(32'h0000A283, 32'h134);
    tick();
    drive(32'h00528333, 32'h138);
    flush = 1'b1;
    #1;
    chk("flush_hz_idstall", id_stall, 0);
    tick();
    chk("flush_hz_valid", ex_valid, 0);
    flush = 1'b0;

    // Illegal opcode 0x7F with rd=6
    drive(32'h0000037F, 32'h13C);
    tick();
    chk("ill_flag", ex_illegal, 1);
    chk("ill_rw", ex_reg_write, 0);
    chk("ill_valid", ex_valid, 1);
    chk("ill_imm", ex_imm, 0);

    // Invalid slot
    drive(32'h002081B3, 32'h140);
    if_valid = 1'b0;
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_rw", ex_reg_write, 0);

    // Asynchronous reset mid-stream
    if_valid = 1'b1;
    tick();
    chk("pre_rst_valid", ex_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_rs1", ex_rs1_val, 0);
    chk("arst_pc", ex_pc, 0);
    chk("arst_rd", ex_rd, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
